iir_capture_buffer: RTL and testbench
=====================================

# iir_capture_buffer

Hardware-side consumer of the IIR_Filter16 output stream: records a triggered window of filtered samples into on-chip RAM for later readout by the host/RTMQ register interface. Replaces file-dump capture with an in-system equivalent. Sits directly after IIR_Filter16's o_filter in the trap-frequency stabilization datapath.

## Interface
- Width, 16, sample width (signed, two's complement)
- AW, 11, RAM address width; depth = 2^AW = 2048 samples
- i_clkp  in  1  system clock, all logic on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_sample  in  Width  signed filter output sample
- i_sample_vld  in  1  i_sample valid this cycle
- i_arm  in  1  single-cycle pulse: arm capture
- i_abort  in  1  single-cycle pulse: return to IDLE
- i_trig  in  1  trigger level/pulse, sampled each cycle
- i_trig_imm  in  1  1 = start capture immediately on arm, ignore i_trig
- i_decim  in  8  keep 1 of every (i_decim+1) valid samples
- i_len  in  AW+1  samples to capture; 0 or >2^AW means 2^AW
- i_rd_en  in  1  read request
- i_rd_addr  in  AW  read address
- o_rd_data  out  Width  RAM word, signed
- o_rd_vld  out  1  o_rd_data valid
- o_state  out  2  current state encoding
- o_done  out  1  high while in DONE
- o_wr_cnt  out  AW+1  samples written in current/last capture

## Operation
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE -> on i_arm: latch i_len (clamped) and i_decim; clear o_wr_cnt and decimation counter; go ARMED, or CAPTURE if i_trig_imm.
- ARMED -> CAPTURE on first cycle with i_trig=1.
- CAPTURE: each i_sample_vld cycle, decimation counter checked; if 0, write i_sample at address o_wr_cnt, increment o_wr_cnt; counter reloads to latched i_decim, else decrements. Counter starts at 0, so first valid sample in CAPTURE is stored.
- Trigger-cycle sample: if i_trig and i_sample_vld coincide in ARMED, that sample is stored as index 0.
- CAPTURE -> DONE on the cycle the write making o_wr_cnt == latched length occurs.
- DONE -> ARMED/CAPTURE on i_arm (same as from IDLE); RAM contents kept until overwritten.
- i_arm in ARMED or CAPTURE: ignored.
- i_abort: any state -> IDLE next cycle; no write that cycle; o_wr_cnt holds. i_abort and i_arm together: abort wins.
- i_decim, i_len changes after arm have no effect until next arm.
- Reads allowed in every state; read during CAPTURE returns current RAM content (old or newly written; same-address read/write returns old data).
- No wrap: addresses never exceed length-1.

## Timing
- Reset values: o_state=0, o_done=0, o_wr_cnt=0, o_rd_vld=0, o_rd_data=0. RAM contents undefined after reset.
- State changes registered: one cycle after the qualifying input.
- Write: sample presented at edge k stored at edge k; o_wr_cnt updates at edge k.
- o_done asserts the cycle after the final write.
- Read latency 1: i_rd_en at edge k -> o_rd_data/o_rd_vld valid after edge k+1; o_rd_vld low when no request; o_rd_data holds last value.
- Reset asserted mid-capture: immediate IDLE, outputs to reset values.

## Structure
- Package iir_cap_pkg: state encoding constants, default AW/Width.
- Sub-module capture_ram: simple dual-port RAM (1 write, 1 registered read), 2^AW x Width, infers BRAM.
- Top: FSM, decimation counter, length clamp, write-address counter.

## Test plan
- Immediate capture: i_trig_imm=1, i_len=8, i_decim=0, ramp samples 100..115 every cycle -> o_done after 8 writes, addr 0..7 read back 100..107, o_wr_cnt=8.
- Decimation: i_len=4, i_decim=2, ramp 0,1,2,... -> stored 0,3,6,9.
- Triggered + gaps: arm, i_trig at cycle 20 with sample -5, i_sample_vld toggling -> index 0 = -5, only valid samples stored, state ARMED until trigger.
- Full depth: i_len=0 -> 2048 samples, o_wr_cnt=2048, addr 2047 holds last, no wrap.
- Abort: abort after 3 of 10 writes -> IDLE, o_wr_cnt=3, i_arm+i_abort same cycle -> stays IDLE.
- Async reset mid-capture -> all outputs zero immediately; re-arm works normally.

Source files
------------

// File: rtl/iir_cap_pkg.sv
// Shared state encoding and default geometry for the IIR capture buffer.
package iir_cap_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned AW_DEF    = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_ram #(
    parameter int unsigned Width = 16,
    parameter int unsigned AW    = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [Width-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [Width-1:0] rd_data,
    output logic                    rd_vld
);

    logic [Width-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address collision returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/iir_capture_buffer.sv
// Triggered, decimated capture of the IIR filter output stream into on-chip RAM.
module iir_capture_buffer
    import iir_cap_pkg::*;
#(
    parameter int unsigned Width = WIDTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic                    i_clkp,
    input  logic                    i_rstn,
    input  logic signed [Width-1:0] i_sample,
    input  logic                    i_sample_vld,
    input  logic                    i_arm,
    input  logic                    i_abort,
    input  logic                    i_trig,
    input  logic                    i_trig_imm,
    input  logic [7:0]              i_decim,
    input  logic [AW:0]             i_len,
    input  logic                    i_rd_en,
    input  logic [AW-1:0]           i_rd_addr,
    output logic signed [Width-1:0] o_rd_data,
    output logic                    o_rd_vld,
    output logic [1:0]              o_state,
    output logic                    o_done,
    output logic [AW:0]             o_wr_cnt
);

    localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

    cap_state_t  state, state_nxt;
    logic [AW:0] len_q, wr_cnt, wr_cnt_inc, len_clamped;
    logic [7:0]  decim_q, dec_cnt;
    logic        arm_go, wr_en, last_wr;

    assign len_clamped = ((i_len == '0) || (i_len > Depth)) ? Depth : i_len;
    assign arm_go      = i_arm && !i_abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign wr_cnt_inc  = wr_cnt + {{AW{1'b0}}, 1'b1};

    // The trigger-cycle sample in ARMED is stored as index 0.
    assign wr_en   = !i_abort && i_sample_vld &&
                     (((state == ST_CAPTURE) && (dec_cnt == '0)) ||
                      ((state == ST_ARMED) && i_trig));
    assign last_wr = wr_en && (wr_cnt_inc == len_q);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (arm_go) state_nxt = i_trig_imm ? ST_CAPTURE : ST_ARMED;
            ST_ARMED:         if (i_trig) state_nxt = last_wr ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE:       if (last_wr) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
        if (i_abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            len_q   <= Depth;
            decim_q <= '0;
            wr_cnt  <= '0;
            dec_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (arm_go) begin
                len_q   <= len_clamped;
                decim_q <= i_decim;
                wr_cnt  <= '0;
                dec_cnt <= '0;
            end else if (wr_en) begin
                wr_cnt  <= wr_cnt_inc;
                dec_cnt <= decim_q;
            end else if ((state == ST_CAPTURE) && i_sample_vld && !i_abort) begin
                dec_cnt <= dec_cnt - 8'd1;
            end
        end
    end

    capture_ram #(
        .Width(Width),
        .AW   (AW)
    ) u_ram (
        .clk    (i_clkp),
        .rst_n  (i_rstn),
        .wr_en  (wr_en),
        .wr_addr(wr_cnt[AW-1:0]),
        .wr_data(i_sample),
        .rd_en  (i_rd_en),
        .rd_addr(i_rd_addr),
        .rd_data(o_rd_data),
        .rd_vld (o_rd_vld)
    );

    assign o_state  = state;
    assign o_done   = (state == ST_DONE);
    assign o_wr_cnt = wr_cnt;

endmodule

// File: tb/tb_iir_capture_buffer.sv
// Directed self-checking bench for iir_capture_buffer.
module tb_iir_capture_buffer;

    localparam int W = 16;
    localparam int A = 11;

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [W-1:0] i_sample;
    logic                i_sample_vld, i_arm, i_abort, i_trig, i_trig_imm, i_rd_en;
    logic [7:0]          i_decim;
    logic [A:0]          i_len;
    logic [A-1:0]        i_rd_addr;
    logic signed [W-1:0] o_rd_data;
    logic                o_rd_vld, o_done;
    logic [1:0]          o_state;
    logic [A:0]          o_wr_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iir_capture_buffer #(.Width(W), .AW(A)) dut (
        .i_clkp      (clk),
        .i_rstn      (rst_n),
        .i_sample    (i_sample),
        .i_sample_vld(i_sample_vld),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_trig      (i_trig),
        .i_trig_imm  (i_trig_imm),
        .i_decim     (i_decim),
        .i_len       (i_len),
        .i_rd_en     (i_rd_en),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_rd_vld    (o_rd_vld),
        .o_state     (o_state),
        .o_done      (o_done),
        .o_wr_cnt    (o_wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [A:0] len, input logic [7:0] decim, input logic imm);
        i_len = len; i_decim = decim; i_trig_imm = imm; i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    task automatic rd(input logic [A-1:0] addr);
        i_rd_en = 1'b1; i_rd_addr = addr;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (o_state !== 2'd0 || o_done !== 1'b0 || o_wr_cnt !== '0 || o_rd_vld !== 1'b0 || o_rd_data !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d done=%0b cnt=%0d rvld=%0b rdata=%0d, want all 0",
                     o_state, o_done, o_wr_cnt, o_rd_vld, o_rd_data);
        end
    endtask

    task automatic test_immediate();
        arm(12'd8, 8'd0, 1'b1);
        checks++;
        if (o_state !== 2'd2 || o_wr_cnt !== '0) begin
            errors++; $display("FAIL imm_arm: state=%0d cnt=%0d, want 2/0", o_state, o_wr_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            i_sample = 16'(100 + i); i_sample_vld = 1'b1;
            tick();
            if (i == 7) begin
                checks++;
                if (o_done !== 1'b1 || o_state !== 2'd3) begin
                    errors++; $display("FAIL imm_done: done=%0b state=%0d, want 1/3", o_done, o_state);
                end
            end
        end
        i_sample_vld = 1'b0;
        checks++;
        if (o_wr_cnt !== 12'd8) begin
            errors++; $display("FAIL imm_cnt: got %0d want 8", o_wr_cnt);
        end
        for (int a = 0; a < 8; a++) begin
            rd(11'(a));
            checks++;
            if (o_rd_vld !== 1'b1 || o_rd_data !== 16'(100 + a)) begin
                errors++; $display("FAIL imm_rd[%0d]: vld=%0b data=%0d want 1/%0d", a, o_rd_vld, o_rd_data, 100 + a);
            end
        end
        tick();
        checks++;
        if (o_rd_vld !== 1'b0 || o_rd_data !== 16'sd107) begin
            errors++; $display("FAIL rd_idle: vld=%0b data=%0d want 0/107", o_rd_vld, o_rd_data);
        end
    endtask

    task automatic test_decimation();
        logic signed [W-1:0] exp [4];
        exp = '{16'sd0, 16'sd3, 16'sd6, 16'sd9};
        arm(12'd4, 8'd2, 1'b1);
        for (int i = 0; i < 14; i++) begin
            i_sample = 16'(i); i_sample_vld = 1'b1;
            tick();
        end
        i_sample_vld = 1'b0;
        checks++;
        if (o_wr_cnt !== 12'd4 || o_state !== 2'd3) begin
            errors++; $display("FAIL dec_end: cnt=%0d state=%0d want 4/3", o_wr_cnt, o_state);
        end
        for (int a = 0; a < 4; a++) begin
            rd(11'(a));
            checks++;
            if (o_rd_data !== exp[a]) begin
                errors++; $display("FAIL dec_rd[%0d]: got %0d want %0d", a, o_rd_data, exp[a]);
            end
        end
    endtask

    task automatic test_triggered();
        logic signed [W-1:0] samp [5];
        logic                vv   [5];
        logic signed [W-1:0] exp  [4];
        samp = '{16'sd7, 16'sd10, 16'sd11, 16'sd20, 16'sd30};
        vv   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp  = '{-16'sd5, 16'sd10, 16'sd20, 16'sd30};
        arm(12'd4, 8'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            i_sample = 16'(1000 + i); i_sample_vld = i[0];
            tick();
        end
        checks++;
        if (o_state !== 2'd1 || o_wr_cnt !== '0) begin
            errors++; $display("FAIL trg_armed: state=%0d cnt=%0d want 1/0", o_state, o_wr_cnt);
        end
        i_trig = 1'b1; i_sample = -16'sd5; i_sample_vld = 1'b1;
        tick();
        i_trig = 1'b0;
        checks++;
        if (o_state !== 2'd2 || o_wr_cnt !== 12'd1) begin
            errors++; $display("FAIL trg_start: state=%0d cnt=%0d want 2/1", o_state, o_wr_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            i_sample = samp[i]; i_sample_vld = vv[i];
            tick();
        end
        i_sample_vld = 1'b0;
        checks++;
        if (o_state !== 2'd3 || o_wr_cnt !== 12'd4) begin
            errors++; $display("FAIL trg_end: state=%0d cnt=%0d want 3/4", o_state, o_wr_cnt);
        end
        for (int a = 0; a < 4; a++) begin
            rd(11'(a));
            checks++;
            if (o_rd_data !== exp[a]) begin
                errors++; $display("FAIL trg_rd[%0d]: got %0d want %0d", a, o_rd_data, exp[a]);
            end
        end
    endtask

    task automatic test_full_depth(input logic [A:0] len, input int ofs);
        arm(len, 8'd0, 1'b1);
        for (int i = 0; i < 2052; i++) begin
            i_sample = 16'(i + ofs); i_sample_vld = 1'b1;
            tick();
        end
        i_sample_vld = 1'b0;
        checks++;
        if (o_wr_cnt !== 12'd2048 || o_done !== 1'b1) begin
            errors++; $display("FAIL full_end(len=%0d): cnt=%0d done=%0b want 2048/1", len, o_wr_cnt, o_done);
        end
        rd(11'd2047);
        checks++;
        if (o_rd_data !== 16'(2047 + ofs)) begin
            errors++; $display("FAIL full_last(len=%0d): got %0d want %0d", len, o_rd_data, 2047 + ofs);
        end
        rd(11'd0);
        checks++;
        if (o_rd_data !== 16'(ofs)) begin
            errors++; $display("FAIL full_nowrap(len=%0d): got %0d want %0d", len, o_rd_data, ofs);
        end
    endtask

    task automatic test_abort();
        arm(12'd10, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            i_sample = 16'(50 + i); i_sample_vld = 1'b1;
            tick();
        end
        i_sample = 16'sd53; i_abort = 1'b1;
        tick();
        i_abort = 1'b0; i_sample_vld = 1'b0;
        checks++;
        if (o_state !== 2'd0 || o_wr_cnt !== 12'd3) begin
            errors++; $display("FAIL abort: state=%0d cnt=%0d want 0/3", o_state, o_wr_cnt);
        end
        rd(11'd3);
        checks++;
        if (o_rd_data !== 16'sd8) begin
            errors++; $display("FAIL abort_nowr: got %0d want 8", o_rd_data);
        end
        rd(11'd2);
        checks++;
        if (o_rd_data !== 16'sd52) begin
            errors++; $display("FAIL abort_rd2: got %0d want 52", o_rd_data);
        end
        i_len = 12'd5; i_trig_imm = 1'b1; i_arm = 1'b1; i_abort = 1'b1;
        tick();
        i_arm = 1'b0; i_abort = 1'b0;
        checks++;
        if (o_state !== 2'd0 || o_wr_cnt !== 12'd3) begin
            errors++; $display("FAIL arm_abort: state=%0d cnt=%0d want 0/3", o_state, o_wr_cnt);
        end
    endtask

    task automatic test_async_reset();
        arm(12'd8, 8'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            i_sample = 16'(60 + i); i_sample_vld = 1'b1;
            tick();
        end
        i_sample_vld = 1'b0;
        rd(11'd1);
        checks++;
        if (o_rd_data !== 16'sd61 || o_state !== 2'd2) begin
            errors++; $display("FAIL pre_rst: data=%0d state=%0d want 61/2", o_rd_data, o_state);
        end
        i_rd_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_state !== 2'd0 || o_done !== 1'b0 || o_wr_cnt !== '0 || o_rd_vld !== 1'b0 || o_rd_data !== '0) begin
            errors++;
            $display("FAIL async_rst: state=%0d done=%0b cnt=%0d rvld=%0b rdata=%0d, want all 0",
                     o_state, o_done, o_wr_cnt, o_rd_vld, o_rd_data);
        end
        i_rd_en = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        arm(12'd2, 8'd0, 1'b1);
        i_sample = 16'sd77; i_sample_vld = 1'b1;
        tick();
        i_sample = 16'sd78;
        tick();
        i_sample_vld = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_wr_cnt !== 12'd2) begin
            errors++; $display("FAIL rearm: done=%0b cnt=%0d want 1/2", o_done, o_wr_cnt);
        end
        rd(11'd0);
        checks++;
        if (o_rd_data !== 16'sd77) begin
            errors++; $display("FAIL rearm_rd0: got %0d want 77", o_rd_data);
        end
        rd(11'd1);
        checks++;
        if (o_rd_data !== 16'sd78) begin
            errors++; $display("FAIL rearm_rd1: got %0d want 78", o_rd_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_sample = '0; i_sample_vld = 1'b0; i_arm = 1'b0; i_abort = 1'b0;
        i_trig = 1'b0; i_trig_imm = 1'b0; i_decim = '0; i_len = '0;
        i_rd_en = 1'b0; i_rd_addr = '0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_immediate();
        test_decimation();
        test_triggered();
        test_full_depth(12'd0, 0);
        test_full_depth(12'd4095, 5);
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
